// File: rtl/data_ram_if.sv
// Load/store request and response bundle between the memory stage and data_ram.
// master: core side drives requests; slave: memory side drives ready and response.
interface data_ram_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_funct3, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_funct3, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_ram.sv
// Byte-addressed data memory: B/H/W loads and stores, wait states, fault response.
// Ports: clk, rst (sync, active-high), bus (data_ram_if.slave).
module data_ram #(
    parameter int          MEM_SIZE    = 8192,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst,
    data_ram_if.slave  bus
);
    localparam int          AW  = $clog2(MEM_SIZE);
    localparam logic [31:0] MSZ = 32'(MEM_SIZE);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_f3;
    logic        ready_q;
    logic        valid_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [7:0]  mem [MEM_SIZE];

    logic [31:0] off;
    logic [31:0] size;
    logic        bad_f3;
    logic        misal;
    logic        oor;
    logic        fault;
    logic        do_access;
    logic [AW-1:0] idx;
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] ld;

    always_comb begin
        off    = r_addr - ADDR_BASE;
        size   = 32'd4;
        bad_f3 = 1'b0;
        case (r_f3)
            3'd0, 3'd4: size = 32'd1;
            3'd1, 3'd5: size = 32'd2;
            3'd2:       size = 32'd4;
            default:    bad_f3 = 1'b1;
        endcase
        // Unsigned loads have no store counterpart.
        if (r_write && r_f3[2])
            bad_f3 = 1'b1;
        misal = (size == 32'd2 && r_addr[0]) ||
                (size == 32'd4 && r_addr[1:0] != 2'b00);
        // Wrap-around of off also catches addresses below ADDR_BASE.
        oor   = off > (MSZ - size);
        fault = bad_f3 | misal | oor;
        idx   = off[AW-1:0];
        b0    = mem[idx];
        b1    = mem[idx + AW'(1)];
        b2    = mem[idx + AW'(2)];
        b3    = mem[idx + AW'(3)];
        case (r_f3)
            3'd0:    ld = {{24{b0[7]}}, b0};
            3'd4:    ld = {24'd0, b0};
            3'd1:    ld = {{16{b1[7]}}, b1, b0};
            3'd5:    ld = {16'd0, b1, b0};
            3'd2:    ld = {b3, b2, b1, b0};
            default: ld = 32'd0;
        endcase
    end

    assign do_access = (state == BUSY) && (cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_write <= bus.req_write;
                        r_addr  <= bus.req_addr;
                        r_f3    <= bus.req_funct3;
                        r_wdata <= bus.req_wdata;
                        cnt     <= 4'(WAIT_CYCLES);
                        ready_q <= 1'b0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        err_q   <= fault;
                        rdata_q <= (fault || r_write) ? 32'd0 : ld;
                        valid_q <= 1'b1;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage is not reset; a store commits only on its access cycle.
    always_ff @(posedge clk) begin
        if (!rst && do_access && r_write && !fault) begin
            mem[idx] <= r_wdata[7:0];
            if (size != 32'd1)
                mem[idx + AW'(1)] <= r_wdata[15:8];
            if (size == 32'd4) begin
                mem[idx + AW'(2)] <= r_wdata[23:16];
                mem[idx + AW'(3)] <= r_wdata[31:24];
            end
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule
